// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 interrupt path: mcause values and scheduler states.
package jedro_1_defines;

    localparam logic [31:0] CSR_MCAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CSR_MCAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CSR_MCAUSE_MEI = 32'h8000_000B;

    // The exception code fits in the low nibble; the interrupt flag is the MSB.
    localparam int IRQ_CODE_W = 4;
    localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MSI = CSR_MCAUSE_MSI[IRQ_CODE_W-1:0];
    localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MTI = CSR_MCAUSE_MTI[IRQ_CODE_W-1:0];
    localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MEI = CSR_MCAUSE_MEI[IRQ_CODE_W-1:0];

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_DRAIN,
        IRQ_TAKE,
        IRQ_WAIT_CLR
    } irq_state_e;

endpackage

// File: rtl/jedro_1_sync.sv
// N-stage single-bit synchroniser for an asynchronous level input.
// Latency STAGES cycles; no backpressure.
module jedro_1_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jedro_1_irq_ctrl.sv
// Interrupt scheduler: synchronises irq lines, stalls fetch, waits for drain, issues a one-cycle take.
// Pending latency SYNC_STAGES cycles; take follows drain by one cycle; exc_busy_i postpones the take.
module jedro_1_irq_ctrl
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  sw_irq_i,
    input  logic                  timer_irq_i,
    input  logic                  ext_irq_i,
    input  logic                  mstatus_mie_i,
    input  logic [2:0]            mie_i,
    input  logic                  exc_busy_i,
    input  logic                  drained_i,
    input  logic [DATA_WIDTH-1:0] next_pc_i,
    output logic [2:0]            irq_pending_o,
    output logic                  stall_ro,
    output logic                  irq_taken_ro,
    output logic [DATA_WIDTH-1:0] irq_cause_ro,
    output logic [DATA_WIDTH-1:0] irq_epc_ro
);

    logic [2:0] irq_raw;
    logic [2:0] elig;
    logic       any_elig;

    logic [IRQ_CODE_W-1:0] sel_code;
    logic [DATA_WIDTH-1:0] sel_cause;

    irq_state_e            state_q, state_d;
    logic                  stall_q, stall_d;
    logic                  taken_q, taken_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] epc_q,   epc_d;

    assign irq_raw = {ext_irq_i, timer_irq_i, sw_irq_i};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        jedro_1_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .d_i    (irq_raw[i]),
            .q_o    (irq_pending_o[i])
        );
    end

    assign elig     = irq_pending_o & mie_i & {3{mstatus_mie_i}};
    assign any_elig = |elig;

    // Fixed priority MEI > MSI > MTI, as in the privileged architecture.
    always_comb begin
        sel_code = '0;
        if (elig[2]) begin
            sel_code = IRQ_CODE_MEI;
        end else if (elig[0]) begin
            sel_code = IRQ_CODE_MSI;
        end else if (elig[1]) begin
            sel_code = IRQ_CODE_MTI;
        end
    end

    always_comb begin
        sel_cause                   = '0;
        sel_cause[DATA_WIDTH-1]     = 1'b1;
        sel_cause[IRQ_CODE_W-1:0]   = sel_code;
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        taken_d = 1'b0;
        cause_d = cause_q;
        epc_d   = epc_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (any_elig && !exc_busy_i) begin
                    state_d = IRQ_DRAIN;
                    stall_d = 1'b1;
                end
            end
            IRQ_DRAIN: begin
                // Selection is redone here so enable changes during drain are honoured.
                if (drained_i && !exc_busy_i && any_elig) begin
                    state_d = IRQ_TAKE;
                    taken_d = 1'b1;
                    cause_d = sel_cause;
                    epc_d   = next_pc_i;
                end else if (!any_elig) begin
                    state_d = IRQ_IDLE;
                    stall_d = 1'b0;
                end
            end
            IRQ_TAKE: begin
                state_d = IRQ_WAIT_CLR;
                stall_d = 1'b0;
            end
            IRQ_WAIT_CLR: begin
                // Wait for trap entry to clear MIE so the same pending line is not taken twice.
                if (!mstatus_mie_i) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IRQ_IDLE;
            stall_q <= 1'b0;
            taken_q <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            taken_q <= taken_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign stall_ro     = stall_q;
    assign irq_taken_ro = taken_q;
    assign irq_cause_ro = cause_q;
    assign irq_epc_ro   = epc_q;

endmodule

// File: tb/tb_jedro_1_irq_ctrl.sv
// Directed bench for jedro_1_irq_ctrl; take pulses are checked against a queue of expected (cause, epc).
module tb_jedro_1_irq_ctrl;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        sw_irq_i, timer_irq_i, ext_irq_i;
    logic        mstatus_mie_i;
    logic [2:0]  mie_i;
    logic        exc_busy_i, drained_i;
    logic [31:0] next_pc_i;
    logic [2:0]  irq_pending_o;
    logic        stall_ro, irq_taken_ro;
    logic [31:0] irq_cause_ro, irq_epc_ro;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    jedro_1_irq_ctrl #(
        .DATA_WIDTH  (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .sw_irq_i      (sw_irq_i),
        .timer_irq_i   (timer_irq_i),
        .ext_irq_i     (ext_irq_i),
        .mstatus_mie_i (mstatus_mie_i),
        .mie_i         (mie_i),
        .exc_busy_i    (exc_busy_i),
        .drained_i     (drained_i),
        .next_pc_i     (next_pc_i),
        .irq_pending_o (irq_pending_o),
        .stall_ro      (stall_ro),
        .irq_taken_ro  (irq_taken_ro),
        .irq_cause_ro  (irq_cause_ro),
        .irq_epc_ro    (irq_epc_ro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stall();
        for (int i = 0; i < 20 && !stall_ro; i++) @(negedge clk);
        chk("wait_stall", {31'd0, stall_ro}, 32'd1);
    endtask

    task automatic wait_take();
        for (int i = 0; i < 20 && !irq_taken_ro; i++) @(negedge clk);
        chk("wait_take", {31'd0, irq_taken_ro}, 32'd1);
    endtask

    task automatic push_exp(input logic [31:0] cause, input logic [31:0] epc);
        exp_t e;
        e.cause = cause;
        e.epc   = epc;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every take pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn_i === 1'b1 && irq_taken_ro === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_take", {31'd0, irq_taken_ro}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("take_cause", irq_cause_ro, e.cause);
                chk("take_epc", irq_epc_ro, e.epc);
            end
        end
    end

    initial begin
        rstn_i = 1'b0;
        sw_irq_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
        mstatus_mie_i = 1'b0; mie_i = 3'b000;
        exc_busy_i = 1'b0; drained_i = 1'b0; next_pc_i = 32'h0;
        cyc(2);
        chk("rst_stall", {31'd0, stall_ro}, 32'd0);
        chk("rst_taken", {31'd0, irq_taken_ro}, 32'd0);
        chk("rst_pending", {29'd0, irq_pending_o}, 32'd0);
        chk("rst_cause", irq_cause_ro, 32'h0);
        chk("rst_epc", irq_epc_ro, 32'h0);
        rstn_i = 1'b1;
        cyc(2);

        // Single timer interrupt with exact cycle timing.
        mstatus_mie_i = 1'b1; mie_i = 3'b010; drained_i = 1'b1; next_pc_i = 32'h0000_0104;
        push_exp(32'h8000_0007, 32'h0000_0104);
        timer_irq_i = 1'b1;
        cyc(1);
        chk("tmr_pend_c1", {29'd0, irq_pending_o}, 32'd0);
        cyc(1);
        chk("tmr_pend_c2", {29'd0, irq_pending_o}, 32'b010);
        chk("tmr_stall_c2", {31'd0, stall_ro}, 32'd0);
        cyc(1);
        chk("tmr_stall_c3", {31'd0, stall_ro}, 32'd1);
        chk("tmr_taken_c3", {31'd0, irq_taken_ro}, 32'd0);
        cyc(1);
        chk("tmr_taken_c4", {31'd0, irq_taken_ro}, 32'd1);
        timer_irq_i = 1'b0;
        cyc(1);
        chk("tmr_taken_c5", {31'd0, irq_taken_ro}, 32'd0);
        chk("tmr_stall_c5", {31'd0, stall_ro}, 32'd0);
        chk("tmr_cause_hold", irq_cause_ro, 32'h8000_0007);
        chk("tmr_epc_hold", irq_epc_ro, 32'h0000_0104);
        mstatus_mie_i = 1'b0;
        cyc(3);

        // Priority: all lines high selects MEI.
        drained_i = 1'b1; next_pc_i = 32'h0000_0200; mie_i = 3'b111;
        sw_irq_i = 1'b1; timer_irq_i = 1'b1; ext_irq_i = 1'b1;
        push_exp(32'h8000_000B, 32'h0000_0200);
        mstatus_mie_i = 1'b1;
        wait_take();
        cyc(1);
        mstatus_mie_i = 1'b0; drained_i = 1'b0;
        cyc(1);
        mstatus_mie_i = 1'b1;
        wait_stall();
        // Disabling meie during drain moves the selection to MSI.
        mie_i = 3'b011; next_pc_i = 32'h0000_0300; drained_i = 1'b1;
        push_exp(32'h8000_0003, 32'h0000_0300);
        wait_take();
        cyc(1);
        mstatus_mie_i = 1'b0; drained_i = 1'b0;
        sw_irq_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
        cyc(4);
        chk("prio_pend_clr", {29'd0, irq_pending_o}, 32'd0);

        // Withdrawal during drain: no take, stall drops.
        mstatus_mie_i = 1'b1; mie_i = 3'b001; sw_irq_i = 1'b1;
        wait_stall();
        sw_irq_i = 1'b0;
        cyc(2);
        chk("wd_stall_held", {31'd0, stall_ro}, 32'd1);
        cyc(1);
        chk("wd_stall_drop", {31'd0, stall_ro}, 32'd0);
        cyc(2);

        // Exception collides with drain for three cycles.
        mie_i = 3'b010; timer_irq_i = 1'b1;
        wait_stall();
        drained_i = 1'b1; exc_busy_i = 1'b1; next_pc_i = 32'h0000_0400;
        push_exp(32'h8000_0007, 32'h0000_0400);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("exc_hold_taken", {31'd0, irq_taken_ro}, 32'd0);
            chk("exc_hold_stall", {31'd0, stall_ro}, 32'd1);
        end
        exc_busy_i = 1'b0;
        cyc(1);
        chk("exc_take", {31'd0, irq_taken_ro}, 32'd1);
        cyc(1);
        chk("exc_single", {31'd0, irq_taken_ro}, 32'd0);

        // Re-take guard: MIE still set with line pending must not retake.
        cyc(6);
        chk("guard_stall", {31'd0, stall_ro}, 32'd0);
        mstatus_mie_i = 1'b0;
        cyc(1);
        next_pc_i = 32'h0000_0500;
        push_exp(32'h8000_0007, 32'h0000_0500);
        mstatus_mie_i = 1'b1;
        wait_take();
        cyc(1);
        mstatus_mie_i = 1'b0; timer_irq_i = 1'b0; drained_i = 1'b0;
        cyc(4);

        // Asynchronous reset in the middle of drain.
        mstatus_mie_i = 1'b1; mie_i = 3'b100; ext_irq_i = 1'b1;
        wait_stall();
        #1 rstn_i = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall_ro}, 32'd0);
        chk("arst_taken", {31'd0, irq_taken_ro}, 32'd0);
        chk("arst_pending", {29'd0, irq_pending_o}, 32'd0);
        chk("arst_cause", irq_cause_ro, 32'h0);
        cyc(1);
        rstn_i = 1'b1;
        cyc(1);
        chk("rel_pend_c1", {29'd0, irq_pending_o}, 32'd0);
        cyc(1);
        chk("rel_pend_c2", {29'd0, irq_pending_o}, 32'b100);
        ext_irq_i = 1'b0; mstatus_mie_i = 1'b0;
        cyc(4);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
